fir_hls_mac_pipe: RTL and testbench

//   Parametrised, pipelined signed multiply-accumulate engine for the multirate FIR datapath.

---
 rtl/fir_hls_mac_pkg.sv | 26 ++
 rtl/fir_hls_mul_pipe.sv | 53 +++++
 rtl/fir_hls_mac_pipe.sv | 159 +++++++++++++++
 tb/tb_fir_hls_mac_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_hls_mac_pkg.sv
// Shared types and width helpers for the FIR MAC engine.
//   clog2_min1 : counter width helper, never returns 0
//   p_w/acc_w  : product and accumulator widths
//   tag_t      : per-product tag travelling with the multiplier pipe
package fir_hls_mac_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int p_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Headroom of clog2(NUM_TAPS) bits makes the tap sum overflow-free.
  function automatic int acc_w(input int pw, input int num_taps);
    return pw + $clog2(num_taps);
  endfunction

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/fir_hls_mul_pipe.sv
// Signed A_W x B_W multiplier, MUL_STAGES registers deep, full precision.
// The tag rides alongside the product so the accumulator knows where each
// sum starts and ends. ce=0 freezes every stage.
//   clk, rst_n : clock, async active-low reset
//   ce         : stage enable
//   a, b       : signed operands
//   tag_i      : tag of the operand pair
//   p, tag_o   : product and its tag after MUL_STAGES cycles
module fir_hls_mul_pipe
  import fir_hls_mac_pkg::*;
#(
  parameter int A_W        = 32,
  parameter int B_W        = 11,
  parameter int MUL_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ce,
  input  logic signed [A_W-1:0]           a,
  input  logic signed [B_W-1:0]           b,
  input  tag_t                            tag_i,
  output logic signed [p_w(A_W,B_W)-1:0]  p,
  output tag_t                            tag_o
);
  localparam int P_W = p_w(A_W, B_W);

  logic signed [P_W-1:0] prod_d;
  logic signed [P_W-1:0] prod_q [MUL_STAGES];
  tag_t                  tag_q  [MUL_STAGES];

  // Signed casts sign-extend both operands, so the P_W-bit product is exact.
  assign prod_d = P_W'(a) * P_W'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MUL_STAGES; s++) begin
        prod_q[s] <= '0;
        tag_q[s]  <= '0;
      end
    end else if (ce) begin
      prod_q[0] <= prod_d;
      tag_q[0]  <= tag_i;
      for (int s = 1; s < MUL_STAGES; s++) begin
        prod_q[s] <= prod_q[s-1];
        tag_q[s]  <= tag_q[s-1];
      end
    end
  end

  assign p     = prod_q[MUL_STAGES-1];
  assign tag_o = tag_q[MUL_STAGES-1];

endmodule

// File: rtl/fir_hls_mac_pipe.sv
// Pipelined signed multiply-accumulate: sums NUM_TAPS products per output.
// Optional feature macro: FIR_HLS_MAC_SAT_EN (saturate instead of wrap).
//   ap_clk, ap_rst_n     : clock, async active-low reset (release is expected
//                          to be synchronised to ap_clk upstream)
//   in_valid/in_ready    : input handshake for din0 (sample) / din1 (coef)
//   out_valid/out_ready  : output handshake for dout
//   dout                 : (sum >>> SHIFT) sized to OUT_W
//   out_sat              : dout was clipped (always 0 without the macro)
// Pipe: accept -> MUL_STAGES mult regs -> acc reg -> output reg.
module fir_hls_mac_pipe
  import fir_hls_mac_pkg::*;
#(
  parameter int A_W        = 32,
  parameter int B_W        = 11,
  parameter int NUM_TAPS   = 4,
  parameter int MUL_STAGES = 2,
  parameter int SHIFT      = 0,
  parameter int OUT_W      = 43
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] dout,
  output logic                    out_sat
);
  localparam int P_W   = p_w(A_W, B_W);
  localparam int ACC_W = acc_w(P_W, NUM_TAPS);
  localparam int CNT_W = clog2_min1(NUM_TAPS);

  logic                    en, accept;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  tag_t                    in_tag, mul_tag;
  logic signed [P_W-1:0]   mul_p;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    acc_vld_q, acc_last_q;
  logic                    load;
  logic [OUT_W-1:0]        res, dout_q, dout_d;
  logic                    res_sat;
  logic                    out_valid_q, out_valid_d;

  // One global enable: the whole pipe stalls only while a result is stuck.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = in_tag.last ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    in_tag       = '0;
    in_tag.valid = accept;
    in_tag.first = (cnt_q == '0);
    in_tag.last  = (cnt_q == CNT_W'(NUM_TAPS-1));
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  fir_hls_mul_pipe #(
    .A_W        (A_W),
    .B_W        (B_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .ce    (en),
    .a     (din0),
    .b     (din1),
    .tag_i (in_tag),
    .p     (mul_p),
    .tag_o (mul_tag)
  );

  // First tap overwrites the accumulator, so no clear cycle between sums.
  always_comb begin
    acc_d = acc_q;
    if (mul_tag.valid) acc_d = mul_tag.first ? ACC_W'(mul_p) : acc_q + ACC_W'(mul_p);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q      <= '0;
      acc_vld_q  <= 1'b0;
      acc_last_q <= 1'b0;
    end else if (en) begin
      acc_q      <= acc_d;
      acc_vld_q  <= mul_tag.valid;
      acc_last_q <= mul_tag.last;
    end
  end

`ifdef FIR_HLS_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_q >>> SHIFT;
    res     = shifted[OUT_W-1:0];
    res_sat = 1'b0;
    if (shifted > OUT_MAX) begin
      res     = OUT_MAX[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (shifted < OUT_MIN) begin
      res     = OUT_MIN[OUT_W-1:0];
      res_sat = 1'b1;
    end
  end

  logic out_sat_q;
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  out_sat_q <= 1'b0;
    else if (load)  out_sat_q <= res_sat;
  end
  assign out_sat = out_sat_q;
`else
  // Plain two's-complement wrap to OUT_W.
  assign res     = OUT_W'(acc_q >>> SHIFT);
  assign res_sat = 1'b0;
  assign out_sat = res_sat;
`endif

  // A completed sum loads even if the old one is being taken this cycle.
  assign load = en && acc_vld_q && acc_last_q;

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    if (load) begin
      out_valid_d = 1'b1;
      dout_d      = res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_fir_hls_mac_pipe.sv
// Directed bench for fir_hls_mac_pipe (A_W=32,B_W=11,NUM_TAPS=4,
// MUL_STAGES=2,SHIFT=0,OUT_W=43). Expected sums are pushed to a queue at
// accept time and popped by a monitor on every output handshake.
module tb_fir_hls_mac_pipe;
  localparam int A_W = 32, B_W = 11, NUM_TAPS = 4, MUL_STAGES = 2, SHIFT = 0, OUT_W = 43;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             in_valid, in_ready;
  logic [A_W-1:0]   din0;
  logic [B_W-1:0]   din1;
  logic             out_valid, out_ready;
  logic [OUT_W-1:0] dout;
  logic             out_sat;

  fir_hls_mac_pipe #(
    .A_W(A_W), .B_W(B_W), .NUM_TAPS(NUM_TAPS),
    .MUL_STAGES(MUL_STAGES), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_sat(out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             s;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0, failures = 0, stall_cnt = 0;
  int     tap = 0;
  longint acc_sum = 0;
  string  cur_test = "reset";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference sizing of a full-precision sum to the output format.
  function automatic exp_t model_out(input longint s);
    exp_t   e;
    longint lim;
    lim = longint'(1) <<< (OUT_W-1);
    e.d = s[OUT_W-1:0];
    e.s = 1'b0;
`ifdef FIR_HLS_MAC_SAT_EN
    if (s > lim - 1) begin
      e.d = {1'b0, {(OUT_W-1){1'b1}}};
      e.s = 1'b1;
    end else if (s < -lim) begin
      e.d = {1'b1, {(OUT_W-1){1'b0}}};
      e.s = 1'b1;
    end
`else
    if (lim == 0) e.s = 1'b1;
`endif
    return e;
  endfunction

  // Entered and left at posedge+1. Holds the pair until accepted.
  task automatic send(input logic signed [A_W-1:0] a, input logic signed [B_W-1:0] b);
    int n;
    n = 0;
    din0 = a; din1 = b; in_valid = 1'b1;
    @(negedge ap_clk);
    while (!in_ready && n < 200) begin
      stall_cnt++; n++;
      @(negedge ap_clk);
    end
    if (!in_ready) begin
      chk({cur_test, "_accept_timeout"}, 64'(in_ready), 64'd1);
    end else begin
      acc_sum += longint'(a) * longint'(b);
      tap++;
      if (tap == NUM_TAPS) begin
        exp_q.push_back(model_out(acc_sum));
        acc_sum = 0;
        tap = 0;
      end
    end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge ap_clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge ap_clk); n++; end
    chk({cur_test, "_drain"}, 64'(exp_q.size()), 64'd0);
    @(posedge ap_clk); #1;
  endtask

  // Scoreboard monitor: one pop per output handshake.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk({cur_test, "_unexpected_out"}, 64'(out_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk({cur_test, "_dout"}, 64'(dout), 64'(mon_e.d));
        chk({cur_test, "_out_sat"}, 64'(out_sat), 64'(mon_e.s));
      end
    end
  end

  initial begin
    int n;
    logic [OUT_W-1:0] held;
    ap_rst_n = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_out_sat", 64'(out_sat), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    idle(2);

    // 1. basic sum -30, latency MUL_STAGES+2 from the last accept
    cur_test = "basic";
    send(1, -1); send(2, -2); send(3, -3); send(4, -4);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge ap_clk); n++; end
    chk("basic_latency", 64'(n), 64'(MUL_STAGES + 2));
    drain();

    // 2. back-to-back outputs, no input bubbles
    cur_test = "b2b";
    stall_cnt = 0;
    repeat (8) send(5, 7);
    chk("b2b_stalls", 64'(stall_cnt), 64'd0);
    drain();

    // 3. backpressure with a partial sum in flight
    cur_test = "bp";
    out_ready = 1'b0;
    send(10, 3); send(-7, 5); send(100, -2); send(1, 1);
    send(-123456, 511); send(77, -1000);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge ap_clk); n++; end
    chk("bp_pending", 64'(out_valid), 64'd1);
    held = dout;
    in_valid = 1'b1; din0 = 32'd42; din1 = 11'd9;
    repeat (4) begin
      @(negedge ap_clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_dout_hold", 64'(dout), 64'(held));
    end
    @(posedge ap_clk); #1;
    out_ready = 1'b1;
    stall_cnt = 0;
    send(42, 9); send(-3, -3);
    chk("bp_release_stalls", 64'(stall_cnt), 64'd0);
    drain();

    // 4. positive overflow corner
    cur_test = "ovf_max";
    repeat (4) send(32'sh7FFFFFFF, 11'sd1023);
    drain();

    // 5. negative-operand corner, sum = 2^43
    cur_test = "ovf_min";
    repeat (4) send(32'sh80000000, -11'sd1024);
    drain();

    // 6. reset mid-accumulation, then (1,1)x4 with bubbles
    cur_test = "rst_mid";
    send(9, 9); send(9, 9);
    ap_rst_n = 1'b0;
    acc_sum = 0; tap = 0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_dout", 64'(dout), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    idle(1);
    send(1, 1); idle(2); send(1, 1); idle(1); send(1, 1); send(1, 1);
    drain();

    idle(5);
    chk("final_out_valid", 64'(out_valid), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
